// File: rtl/timer_cfg_pkg.sv
//------------------------------------------------------------------------------
// Module  : timer_cfg_pkg
// Brief   : Shared types for the timer configuration master.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timer_cfg_pkg;

    localparam int CLR_BIT_DEF = 10;
    localparam int EN_BIT_DEF  = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_CNT   = 4'd1,
        ST_WR_PRD   = 4'd2,
        ST_WR_CON   = 4'd3,
        ST_GAP      = 4'd4,
        ST_RUN      = 4'd5,
        ST_CLR      = 4'd6,
        ST_CLR_WAIT = 4'd7,
        ST_STOP     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        NW_CNT = 2'd0,
        NW_PRD = 2'd1,
        NW_CON = 2'd2
    } next_wr_e;

endpackage

`default_nettype wire

// File: rtl/timer_cfg_master.sv
//------------------------------------------------------------------------------
// Module  : timer_cfg_master
// Brief   : Programs CNT/PRD/CON of one timer, services its interrupts, stops it.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_cfg_master
    import timer_cfg_pkg::*;
#(
    parameter int DW      = 16,
    parameter int GAP_CYC = 1,
    parameter int CLR_BIT = CLR_BIT_DEF,
    parameter int EN_BIT  = EN_BIT_DEF,
    parameter int IRQ_W   = 8,
    parameter int CLR_TMO = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DW-1:0]    cfg_cnt,
    input  logic [DW-1:0]    cfg_prd,
    input  logic [DW-1:0]    cfg_con,
    input  logic [IRQ_W-1:0] cfg_nirq,
    input  logic             stop_req,
    input  logic             tmr_int,
    output logic             tmr_cnt_wr,
    output logic             tmr_prd_wr,
    output logic             tmr_con_wr,
    output logic [DW-1:0]    icb_wdat,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IRQ_W-1:0] irq_cnt
);

    localparam int            TW       = $clog2(CLR_TMO + 1);
    localparam logic [DW-1:0] CLR_MASK = DW'(1) << CLR_BIT;
    localparam logic [DW-1:0] EN_MASK  = DW'(1) << EN_BIT;

    state_e           state_q, state_d;
    next_wr_e         next_q, next_d;
    logic [3:0]       gap_q, gap_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [DW-1:0]    prd_q, prd_d;
    logic [DW-1:0]    con_q, con_d;
    logic [IRQ_W-1:0] nirq_q, nirq_d;
    logic [IRQ_W-1:0] irq_cnt_q, irq_cnt_d;
    logic             err_q, err_d;
    logic             stop_q, stop_d;
    logic             done_q, done_d;
    logic [DW-1:0]    wdat_q, wdat_d;
    logic             stop_seen;
    logic             stop_cond;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            next_q    <= NW_CNT;
            gap_q     <= '0;
            tmo_q     <= '0;
            prd_q     <= '0;
            con_q     <= '0;
            nirq_q    <= '0;
            irq_cnt_q <= '0;
            err_q     <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            wdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            next_q    <= next_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            prd_q     <= prd_d;
            con_q     <= con_d;
            nirq_q    <= nirq_d;
            irq_cnt_q <= irq_cnt_d;
            err_q     <= err_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            wdat_q    <= wdat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        next_d    = next_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        prd_d     = prd_q;
        con_d     = con_q;
        nirq_d    = nirq_q;
        irq_cnt_d = irq_cnt_q;
        err_d     = err_q;
        stop_d    = stop_q;
        done_d    = 1'b0;
        wdat_d    = wdat_q;
        stop_seen = stop_q | stop_req;
        stop_cond = ((nirq_q != '0) && (irq_cnt_q == nirq_q)) || stop_seen;

        // Stop requests are remembered from accept until the FSM returns to idle.
        if (state_q != ST_IDLE) begin
            stop_d = stop_seen;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_d   = ST_WR_CNT;
                    prd_d     = cfg_prd;
                    con_d     = cfg_con;
                    nirq_d    = cfg_nirq;
                    irq_cnt_d = '0;
                    err_d     = 1'b0;
                    stop_d    = 1'b0;
                    wdat_d    = cfg_cnt;
                end
            end
            ST_WR_CNT: begin
                if (GAP_CYC == 0) begin
                    state_d = ST_WR_PRD;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = 4'(GAP_CYC);
                    next_d  = NW_PRD;
                end
            end
            ST_WR_PRD: begin
                if (GAP_CYC == 0) begin
                    state_d = ST_WR_CON;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = 4'(GAP_CYC);
                    next_d  = NW_CON;
                end
            end
            ST_WR_CON: state_d = stop_seen ? ST_STOP : ST_RUN;
            ST_GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = (next_q == NW_CON) ? ST_WR_CON : ST_WR_PRD;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_RUN: begin
                // A coincident interrupt wins over stop; the latch finishes the job later.
                if (tmr_int) begin
                    state_d = ST_CLR;
                    if (irq_cnt_q != '1) begin
                        irq_cnt_d = irq_cnt_q + IRQ_W'(1);
                    end
                end else if (stop_seen) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLR: begin
                state_d = ST_CLR_WAIT;
                tmo_d   = '0;
            end
            ST_CLR_WAIT: begin
                if (!tmr_int) begin
                    state_d = stop_cond ? ST_STOP : ST_RUN;
                end else if (tmo_q == TW'(CLR_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_STOP: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Write data is loaded on entry to each write state and then held.
        case (state_d)
            ST_WR_PRD: wdat_d = prd_q;
            ST_WR_CON: wdat_d = con_q;
            ST_CLR:    wdat_d = con_q | CLR_MASK;
            ST_STOP:   wdat_d = (con_q & ~EN_MASK) | CLR_MASK;
            default:   ;
        endcase
    end

    always_comb begin
        tmr_cnt_wr = (state_q == ST_WR_CNT);
        tmr_prd_wr = (state_q == ST_WR_PRD);
        tmr_con_wr = (state_q == ST_WR_CON) || (state_q == ST_CLR) || (state_q == ST_STOP);
        cfg_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
    end

    assign icb_wdat = wdat_q;
    assign done     = done_q;
    assign err      = err_q;
    assign irq_cnt  = irq_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_cfg_master.sv
//------------------------------------------------------------------------------
// Module  : tb_timer_cfg_master
// Brief   : Scoreboard bench for timer_cfg_master (GAP_CYC=1 and GAP_CYC=0).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer_cfg_master;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        cfg_valid, stop_req, tmr_int;
    logic [15:0] cfg_cnt, cfg_prd, cfg_con;
    logic [7:0]  cfg_nirq;
    logic        cfg_ready, tmr_cnt_wr, tmr_prd_wr, tmr_con_wr, busy, done, err;
    logic [15:0] icb_wdat;
    logic [7:0]  irq_cnt;

    logic        v0, stop0;
    logic        ready0, c0, p0, n0, busy0, done0, err0;
    logic [15:0] wd0;
    logic [7:0]  irq0;

    always #5 clk = ~clk;

    timer_cfg_master #(.GAP_CYC(1)) u_dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_cnt(cfg_cnt), .cfg_prd(cfg_prd), .cfg_con(cfg_con), .cfg_nirq(cfg_nirq),
        .stop_req(stop_req), .tmr_int(tmr_int),
        .tmr_cnt_wr(tmr_cnt_wr), .tmr_prd_wr(tmr_prd_wr), .tmr_con_wr(tmr_con_wr),
        .icb_wdat(icb_wdat), .busy(busy), .done(done), .err(err), .irq_cnt(irq_cnt)
    );

    timer_cfg_master #(.GAP_CYC(0)) u_dut_g0 (
        .sys_clk(clk), .sys_rst(sys_rst),
        .cfg_valid(v0), .cfg_ready(ready0),
        .cfg_cnt(16'h000A), .cfg_prd(16'h000B), .cfg_con(16'h0001), .cfg_nirq(8'd0),
        .stop_req(stop0), .tmr_int(1'b0),
        .tmr_cnt_wr(c0), .tmr_prd_wr(p0), .tmr_con_wr(n0),
        .icb_wdat(wd0), .busy(busy0), .done(done0), .err(err0), .irq_cnt(irq0)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t expq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] d, input int c);
        wr_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    // Issue a command; returns one step into cycle 1.
    task automatic accept(input logic [15:0] c, input logic [15:0] p,
                          input logic [15:0] n, input logic [7:0] q);
        chk("ready_before_accept", {31'd0, cfg_ready}, 32'd1);
        cfg_cnt   = c;
        cfg_prd   = p;
        cfg_con   = n;
        cfg_nirq  = q;
        cfg_valid = 1'b1;
        tick;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc, output int n);
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            tick;
            n++;
        end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    int waited;

    initial begin
        sys_rst   = 1'b1;
        cfg_valid = 1'b0;
        stop_req  = 1'b0;
        tmr_int   = 1'b0;
        cfg_cnt   = '0;
        cfg_prd   = '0;
        cfg_con   = '0;
        cfg_nirq  = '0;
        v0        = 1'b0;
        stop0     = 1'b0;

        fork
            begin : monitor
                int          cyc;
                int          ns;
                logic [1:0]  k;
                logic [7:0]  cy_act, cy_exp;
                wr_t         e;
                cyc = 0;
                forever begin
                    @(negedge clk);
                    cyc++;
                    ns = int'(tmr_cnt_wr) + int'(tmr_prd_wr) + int'(tmr_con_wr);
                    if (ns > 1) begin
                        chk("strobe_onehot", 32'(ns), 32'd1);
                    end else if (ns == 1) begin
                        k = tmr_cnt_wr ? 2'd0 : (tmr_prd_wr ? 2'd1 : 2'd2);
                        if (expq.size() == 0) begin
                            chk("unexpected_write_queue_depth", 32'(expq.size()), 32'd1);
                        end else begin
                            e      = expq.pop_front();
                            cy_act = 8'(cyc);
                            cy_exp = (e.cyc < 0) ? cy_act : 8'(e.cyc);
                            chk("write_kind_data_cycle", {6'd0, k, icb_wdat, cy_act},
                                {6'd0, e.kind, e.data, cy_exp});
                        end
                    end
                    if (cfg_valid && cfg_ready) cyc = 0;
                end
            end
        join_none

        repeat (3) tick;
        sys_rst = 1'b0;
        tick;
        chk("rst_ready_busy_done_err", {28'd0, cfg_ready, busy, done, err}, 32'h8);
        chk("rst_wdat_irq", {8'd0, icb_wdat, irq_cnt}, 32'd0);
        chk("rst_strobes", {29'd0, tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}, 32'd0);

        // Basic programming, one interrupt, auto-stop at nirq=1.
        push(2'd0, 16'h0000, 1);
        push(2'd1, 16'h0020, 3);
        push(2'd2, 16'h0001, 5);
        accept(16'h0000, 16'h0020, 16'h0001, 8'd1);
        repeat (5) tick;
        chk("t1_busy_in_run", {31'd0, busy}, 32'd1);
        push(2'd2, 16'h0401, -1);
        tmr_int = 1'b1;
        tick;
        chk("t1_irq_cnt", 32'(irq_cnt), 32'd1);
        tmr_int = 1'b0;
        push(2'd2, 16'h0400, -1);
        wait_done("t1_done", 20, waited);
        chk("t1_ready_after_done", {30'd0, cfg_ready, busy}, 32'h2);
        tick;
        chk("t1_done_one_pulse", {31'd0, done}, 32'd0);

        // Free-running: three interrupts then stop_req.
        push(2'd0, 16'h0005, 1);
        push(2'd1, 16'h0010, 3);
        push(2'd2, 16'h0001, 5);
        accept(16'h0005, 16'h0010, 16'h0001, 8'd0);
        repeat (5) tick;
        for (int i = 0; i < 3; i++) begin
            push(2'd2, 16'h0401, -1);
            tmr_int = 1'b1;
            tick;
            tmr_int = 1'b0;
            repeat (3) tick;
            chk("t2_irq_cnt_step", 32'(irq_cnt), 32'(i + 1));
        end
        push(2'd2, 16'h0400, -1);
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        wait_done("t2_done", 20, waited);
        chk("t2_irq_cnt_final", 32'(irq_cnt), 32'd3);

        // stop_req coincident with tmr_int: interrupt serviced first.
        push(2'd0, 16'h0001, 1);
        push(2'd1, 16'h0002, 3);
        push(2'd2, 16'h0001, 5);
        accept(16'h0001, 16'h0002, 16'h0001, 8'd0);
        repeat (5) tick;
        push(2'd2, 16'h0401, -1);
        push(2'd2, 16'h0400, -1);
        tmr_int  = 1'b1;
        stop_req = 1'b1;
        tick;
        tmr_int  = 1'b0;
        stop_req = 1'b0;
        wait_done("t3_done", 20, waited);
        chk("t3_irq_cnt", 32'(irq_cnt), 32'd1);

        // Interrupt stuck high: clear timeout.
        push(2'd0, 16'h0003, 1);
        push(2'd1, 16'h0004, 3);
        push(2'd2, 16'h0001, 5);
        accept(16'h0003, 16'h0004, 16'h0001, 8'd0);
        repeat (5) tick;
        push(2'd2, 16'h0401, -1);
        push(2'd2, 16'h0400, -1);
        tmr_int = 1'b1;
        wait_done("t4_done", 40, waited);
        chk("t4_err_set", {31'd0, err}, 32'd1);
        chk("t4_waited_at_least_tmo", {31'd0, (waited >= 16)}, 32'd1);
        tmr_int = 1'b0;
        repeat (3) tick;
        chk("t4_err_sticky", {30'd0, err, busy}, 32'h2);

        // Reset right after the PRD strobe: CON must never appear.
        push(2'd0, 16'h0011, 1);
        push(2'd1, 16'h0022, 3);
        accept(16'h0011, 16'h0022, 16'h0001, 8'd0);
        chk("t5_err_cleared_on_accept", {31'd0, err}, 32'd0);
        repeat (3) tick;
        sys_rst = 1'b1;
        tick;
        sys_rst = 1'b0;
        chk("t5_rst_flags", {28'd0, cfg_ready, busy, done, err}, 32'h8);
        chk("t5_rst_wdat_irq", {8'd0, icb_wdat, irq_cnt}, 32'd0);
        repeat (8) tick;
        chk("t5_no_pending_con", 32'(expq.size()), 32'd0);
        push(2'd0, 16'h0033, 1);
        push(2'd1, 16'h0044, 3);
        push(2'd2, 16'h0001, 5);
        accept(16'h0033, 16'h0044, 16'h0001, 8'd1);
        repeat (5) tick;
        push(2'd2, 16'h0400, -1);
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        wait_done("t5_restart_done", 20, waited);

        // stop_req during configuration: WR_CON goes straight to STOP.
        push(2'd0, 16'h0007, 1);
        push(2'd1, 16'h0008, 3);
        push(2'd2, 16'h0003, 5);
        push(2'd2, 16'h0402, 6);
        accept(16'h0007, 16'h0008, 16'h0003, 8'd0);
        tick;
        stop_req = 1'b1;
        tick;
        stop_req = 1'b0;
        wait_done("t6_done", 20, waited);
        chk("t6_irq_cnt", 32'(irq_cnt), 32'd0);

        // GAP_CYC=0 instance: back-to-back strobes, cfg_valid held high.
        begin
            logic [2:0]  stb_tab [1:5];
            logic [15:0] dat_tab [1:5];
            stb_tab[1] = 3'b100; dat_tab[1] = 16'h000A;
            stb_tab[2] = 3'b010; dat_tab[2] = 16'h000B;
            stb_tab[3] = 3'b001; dat_tab[3] = 16'h0001;
            stb_tab[4] = 3'b000; dat_tab[4] = 16'h0001;
            stb_tab[5] = 3'b001; dat_tab[5] = 16'h0400;
            v0 = 1'b1;
            tick;
            for (int i = 1; i <= 5; i++) begin
                chk("g0_strobes", {29'd0, c0, p0, n0}, {29'd0, stb_tab[i]});
                chk("g0_wdat", {16'd0, wd0}, {16'd0, dat_tab[i]});
                chk("g0_ready_low_busy", {30'd0, ready0, busy0}, 32'h1);
                if (i == 4) begin
                    stop0 = 1'b1;
                    v0    = 1'b0;
                end else begin
                    stop0 = 1'b0;
                end
                tick;
            end
            stop0 = 1'b0;
            chk("g0_done", {30'd0, done0, ready0}, 32'h3);
        end

        repeat (2) tick;
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_cfg_master.md
Name: timer_cfg_master

Overview:
Register-write initiator that drives the timer's write-strobe interface (tmr_cnt_wr / tmr_prd_wr / tmr_con_wr + icb_wdat) and consumes its interrupt. It accepts one configuration command, then programs CNT, PRD and CON in that order. It services each tmr_int by writing a clear-pending to CON, and stops the timer after N interrupts or on request. It sits between a control sequencer/CPU-side shim and one timer instance.

Parameters:
DW, 16, data width of icb_wdat and config fields
GAP_CYC, 1, idle cycles between consecutive write strobes (0..15)
CLR_BIT, 10, CON bit index for the clear-pending request
EN_BIT, 0, CON bit index for the timer enable
IRQ_W, 8, width of interrupt counters
CLR_TMO, 16, max cycles to wait for tmr_int to drop after a clear

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
cfg_valid  in  1  command request
cfg_ready  out  1  high only in IDLE; command accepted when cfg_valid & cfg_ready
cfg_cnt  in  DW  initial count value
cfg_prd  in  DW  period value
cfg_con  in  DW  control value (EN_BIT normally set)
cfg_nirq  in  IRQ_W  interrupts to service before auto-stop; 0 = run until stop_req
stop_req  in  1  single-cycle stop pulse, latched
tmr_int  in  1  timer interrupt (level)
tmr_cnt_wr  out  1  CNT write strobe
tmr_prd_wr  out  1  PRD write strobe
tmr_con_wr  out  1  CON write strobe
icb_wdat  out  DW  write data
busy  out  1  high whenever not IDLE
done  out  1  one-cycle pulse on return to IDLE
err  out  1  sticky clear-timeout flag, cleared on next command accept
irq_cnt  out  IRQ_W  interrupts serviced since last accept, saturating

Behaviour:
- Reset values: all strobes 0, icb_wdat 0, cfg_ready 1, busy 0, done 0, err 0, irq_cnt 0; FSM in IDLE; stop latch cleared.
- Reset asserted mid-operation: strobes are 0 from the next edge. No partial write is completed.
- Command accept (cycle 0):
  - latch cnt/prd/con/nirq; clear irq_cnt and err.
  - State sequence: WR_CNT -> GAP -> WR_PRD -> GAP -> WR_CON -> RUN.
- Strobes:
  - Each strobe is high for exactly one cycle. At most one strobe is high in any cycle.
  - icb_wdat is valid in the strobe cycle and holds that value until the next write.
- Timing with GAP_CYC=g: tmr_cnt_wr at cycle 1, tmr_prd_wr at cycle 2+g, tmr_con_wr at cycle 3+2g.
- GAP counter: 4 bits, reloaded with GAP_CYC on entry to GAP. With g=0 the strobes fall on consecutive cycles.
- RUN, on tmr_int high:
  - go to CLR: tmr_con_wr=1, icb_wdat = con | (1<<CLR_BIT).
  - irq_cnt increments (saturating at all-ones) in the CLR cycle.
- CLR_WAIT: wait for tmr_int low.
  - On low: go to RUN, unless the stop condition holds, then go to STOP.
  - If tmr_int is still high after CLR_TMO cycles: set err and go to STOP.
- Stop condition: (cfg_nirq != 0 && irq_cnt == cfg_nirq) or stop latch set.
- STOP: one write, tmr_con_wr=1, icb_wdat = (con & ~(1<<EN_BIT)) | (1<<CLR_BIT). Next cycle: done=1, return to IDLE.
- stop_req while configuring (WR_*/GAP): latched. The config sequence completes, then WR_CON goes directly to STOP.
- stop_req in RUN with tmr_int low: go to STOP next cycle.
- stop_req in the same cycle as tmr_int in RUN: the interrupt takes priority. It is counted and cleared through CLR/CLR_WAIT, then STOP.
- stop_req in IDLE: ignored.
- cfg_valid while busy: not accepted (cfg_ready=0). No queuing.
- tmr_int already high when RUN is entered: serviced immediately as a normal interrupt.

Decomposition:
- Package timer_cfg_pkg holds:
  - state enum: IDLE, WR_CNT, WR_PRD, WR_CON, GAP, RUN, CLR, CLR_WAIT, STOP
  - CLR_BIT / EN_BIT defaults
  - a "next write" selector enum (CNT/PRD/CON) used by GAP to choose its successor.
- Single flat module; no sub-module warranted.

Test Plan:
- Accept cnt=0x0000, prd=0x0020, con=0x0001, nirq=1, g=1 -> strobes cnt@1, prd@3, con@5 with icb_wdat 0x0000/0x0020/0x0001.
- Then drive tmr_int -> CON write 0x0401, irq_cnt=1. After tmr_int drops: STOP write 0x0400, done pulse, cfg_ready=1.
- nirq=0, three interrupts, then stop_req -> three 0x0401 writes, irq_cnt=3, then one 0x0400 write and done.
- stop_req and tmr_int in the same RUN cycle -> 0x0401 write first, then 0x0400. irq_cnt increments by 1.
- Hold tmr_int high after clear -> after 16 cycles err=1, write 0x0400, done. err stays 1 until next accept, then reads 0.
- Assert sys_rst in the cycle after tmr_prd_wr -> no tmr_con_wr ever appears; all outputs at reset values. A new command restarts the sequence from cnt@1.
- Case g=0 -> CNT/PRD/CON strobes on cycles 1, 2, 3, never overlapping. cfg_valid held high while busy is not re-accepted.
